// File: rtl/axi_wr_mux_pkg.sv
// Shared types for the AXI write multiplexer: FSM state encoding and B-channel width.
package axi_wr_mux_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/axi_wr_mux_port.sv
// Per-port upstream gating: only the selected port sees ready/bvalid/bresp/acknowledge.
module axi_wr_mux_port
  import axi_wr_mux_pkg::*;
(
  input  logic              hit,
  input  wr_state_e         state,
  input  logic              m_awready,
  input  logic              m_wready,
  input  logic              m_bvalid,
  input  logic [RESP_W-1:0] m_bresp,
  input  logic              s_bready,
  output logic              s_awready,
  output logic              s_wready,
  output logic              s_bvalid,
  output logic [RESP_W-1:0] s_bresp,
  output logic              ack
);

  logic in_resp;

  assign in_resp   = hit && (state == ST_RESP);
  assign s_awready = hit && (state == ST_ADDR) && m_awready;
  assign s_wready  = hit && (state == ST_DATA) && m_wready;
  assign s_bvalid  = in_resp && m_bvalid;
  assign s_bresp   = in_resp ? m_bresp : '0;
  // Completion pulse: B handshake of the selected port.
  assign ack       = in_resp && m_bvalid && s_bready;

endmodule

// File: rtl/axi_wr_mux.sv
// N:1 AXI write multiplexer driven by an external registered arbiter; one transaction in flight.
module axi_wr_mux
  import axi_wr_mux_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_W     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,

  input  logic [PORTS*ADDR_WIDTH-1:0]  s_awaddr,
  input  logic [PORTS-1:0]             s_awvalid,
  output logic [PORTS-1:0]             s_awready,
  input  logic [PORTS*DATA_WIDTH-1:0]  s_wdata,
  input  logic [PORTS-1:0]             s_wlast,
  input  logic [PORTS-1:0]             s_wvalid,
  output logic [PORTS-1:0]             s_wready,
  output logic [PORTS*RESP_W-1:0]      s_bresp,
  output logic [PORTS-1:0]             s_bvalid,
  input  logic [PORTS-1:0]             s_bready,

  output logic [ADDR_WIDTH-1:0]        m_awaddr,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic                         m_wlast,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic [RESP_W-1:0]            m_bresp,
  input  logic                         m_bvalid,
  output logic                         m_bready,

  output logic [PORTS-1:0]             arb_request,
  output logic [PORTS-1:0]             arb_acknowledge,
  input  logic [PORTS-1:0]             arb_grant,
  input  logic                         arb_grant_valid,
  input  logic [SEL_W-1:0]             arb_grant_encoded
);

  wr_state_e        state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;

  // The encoded grant carries the same information as the one-hot vector.
  logic unused_grant;
  assign unused_grant = ^arb_grant;

  // Reset forces every output low at once, request included.
  assign arb_request = s_awvalid & {PORTS{resetn}};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    m_awaddr  = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wlast   = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_grant_valid) begin
          sel_nxt   = arb_grant_encoded;
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_awaddr  = s_awaddr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        m_awvalid = s_awvalid[sel];
        if (m_awvalid && m_awready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        m_wdata  = s_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
        m_wlast  = s_wlast[sel];
        m_wvalid = s_wvalid[sel];
        if (m_wvalid && m_wready && m_wlast) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        m_bready = s_bready[sel];
        if (m_bvalid && m_bready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    axi_wr_mux_port u_port (
      .hit       (sel == SEL_W'(i)),
      .state     (state),
      .m_awready (m_awready),
      .m_wready  (m_wready),
      .m_bvalid  (m_bvalid),
      .m_bresp   (m_bresp),
      .s_bready  (s_bready[i]),
      .s_awready (s_awready[i]),
      .s_wready  (s_wready[i]),
      .s_bvalid  (s_bvalid[i]),
      .s_bresp   (s_bresp[i*RESP_W +: RESP_W]),
      .ack       (arb_acknowledge[i])
    );
  end

endmodule

// File: tb/tb_axi_wr_mux.sv
// Directed bench: upstream masters, downstream slave and a round-robin arbiter around axi_wr_mux.
module tb_axi_wr_mux;

  localparam int P = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [P*32-1:0] s_awaddr;
  logic [P-1:0]  s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid;
  logic [P-1:0]  s_bready = '1;
  logic [P*32-1:0] s_wdata;
  logic [P*2-1:0] s_bresp;
  logic [31:0]   m_awaddr, m_wdata;
  logic          m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]    m_bresp;
  logic [P-1:0]  arb_request, arb_acknowledge, arb_grant;
  logic          arb_grant_valid;
  logic [1:0]    arb_grant_encoded;

  always #5 clk = ~clk;

  axi_wr_mux #(.PORTS(P), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .arb_request(arb_request), .arb_acknowledge(arb_acknowledge),
    .arb_grant(arb_grant), .arb_grant_valid(arb_grant_valid),
    .arb_grant_encoded(arb_grant_encoded)
  );

  // Arbiter: round-robin, grant held until acknowledged; test may override it.
  logic       rr_gv;
  logic [1:0] rr_enc;
  int         rr_last, rr_pick;
  logic       arb_force = 1'b0, f_gv = 1'b0;
  logic [1:0] f_enc = '0, f_exp = '0;
  logic [1:0] exp_sel;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_gv <= 1'b0; rr_enc <= '0; rr_last <= P-1;
    end else if (!rr_gv || arb_acknowledge[rr_enc]) begin
      rr_pick = -1;
      for (int k = 1; k <= P; k++)
        if (rr_pick < 0 && arb_request[(rr_last+k)%P]) rr_pick = (rr_last+k)%P;
      if (rr_pick >= 0) begin
        rr_gv <= 1'b1; rr_enc <= 2'(rr_pick); rr_last <= rr_pick;
      end else rr_gv <= 1'b0;
    end
  end

  assign arb_grant_valid   = arb_force ? f_gv  : rr_gv;
  assign arb_grant_encoded = arb_force ? f_enc : rr_enc;
  assign arb_grant         = arb_grant_valid ? (P'(1) << arb_grant_encoded) : '0;
  assign exp_sel           = arb_force ? f_exp : rr_enc;

  // Master / slave models and logs
  bit          mst_aw_pend[P], mst_w_act[P];
  logic [31:0] mst_addr[P];
  int          mst_nb[P], mst_beat[P];
  int          aw_cnt, cfg_aw_stall;
  bit          cfg_w_toggle;
  logic [1:0]  cfg_bresp;

  logic [31:0] aw_q[$];
  logic [32:0] w_q[$];
  logic [3:0]  ack_q[$], bv_q[$];
  logic [7:0]  bresp_q[$];
  int          ack_cyc_q[$], awv_rise_q[$], aw_fire_q[$];
  int          cyc, viol;
  bit          awv_prev;
  int          n_cmp, n_bad;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bdat(input int p, input int k);
    return 32'hD000_0000 + 32'(p*256 + k);
  endfunction

  function automatic logic [127:0] outs();
    return {32'h0, s_awready, s_wready, s_bresp, s_bvalid, m_awaddr, m_awvalid, m_wdata,
            m_wlast, m_wvalid, m_bready, arb_request, arb_acknowledge};
  endfunction

  task automatic drive_master();
    for (int p = 0; p < P; p++) begin
      s_awvalid[p]        = mst_aw_pend[p];
      s_awaddr[p*32 +: 32] = mst_addr[p];
      s_wvalid[p]         = mst_w_act[p];
      s_wdata[p*32 +: 32] = bdat(p, mst_beat[p]);
      s_wlast[p]          = mst_w_act[p] && (mst_beat[p] == mst_nb[p]-1);
    end
  endtask

  task automatic start_txn(input int p, input logic [31:0] a, input int nb);
    mst_aw_pend[p] = 1; mst_w_act[p] = 1; mst_addr[p] = a; mst_nb[p] = nb; mst_beat[p] = 0;
    drive_master();
  endtask

  task automatic clear_models();
    for (int p = 0; p < P; p++) begin
      mst_aw_pend[p] = 0; mst_w_act[p] = 0; mst_addr[p] = '0; mst_nb[p] = 0; mst_beat[p] = 0;
    end
    aw_cnt = cfg_aw_stall; m_awready = (aw_cnt == 0); m_wready = 1'b1;
    m_bvalid = 1'b0; m_bresp = '0;
    drive_master();
  endtask

  task automatic clear_logs();
    aw_q.delete(); w_q.delete(); ack_q.delete(); bv_q.delete(); bresp_q.delete();
    ack_cyc_q.delete(); awv_rise_q.delete(); aw_fire_q.delete(); viol = 0; awv_prev = 0;
  endtask

  // One clock: sample at negedge, update the models just after the rising edge.
  task automatic cycle();
    logic [3:0] aw_f, w_f, oh, pend;
    logic maw, mw, mb, mwl, mawv;
    @(negedge clk);
    cyc++;
    aw_f = s_awvalid & s_awready; w_f = s_wvalid & s_wready;
    maw = m_awvalid & m_awready; mw = m_wvalid & m_wready; mb = m_bvalid & m_bready;
    mwl = m_wlast; mawv = m_awvalid;
    oh = 4'b1 << exp_sel;
    for (int p = 0; p < P; p++) pend[p] = mst_aw_pend[p];
    if (maw) begin aw_q.push_back(m_awaddr); aw_fire_q.push_back(cyc); end
    if (m_awvalid && !awv_prev) awv_rise_q.push_back(cyc);
    awv_prev = m_awvalid;
    if (mw) w_q.push_back({m_wlast, m_wdata});
    if (arb_acknowledge != 0) begin ack_q.push_back(arb_acknowledge); ack_cyc_q.push_back(cyc); end
    if (mb) begin bresp_q.push_back(s_bresp); bv_q.push_back(s_bvalid); end
    if (((s_awready | s_wready | s_bvalid | arb_acknowledge) & ~oh) != 0) viol++;
    for (int p = 0; p < P; p++) if (!oh[p] && s_bresp[p*2 +: 2] != 2'b00) viol++;
    if (m_wvalid && (s_wready != (m_wready ? oh : 4'b0))) viol++;
    if ((w_f & pend) != 0) viol++;
    if (aw_f != (maw ? oh : 4'b0)) viol++;
    if (w_f != (mw ? oh : 4'b0)) viol++;
    @(posedge clk); #1;
    for (int p = 0; p < P; p++) begin
      if (aw_f[p]) mst_aw_pend[p] = 0;
      if (w_f[p]) begin
        mst_beat[p]++;
        if (mst_beat[p] == mst_nb[p]) mst_w_act[p] = 0;
      end
    end
    if (maw) aw_cnt = cfg_aw_stall;
    else if (mawv && aw_cnt > 0) aw_cnt--;
    m_awready = (aw_cnt == 0);
    m_wready  = cfg_w_toggle ? !m_wready : 1'b1;
    if (mb) m_bvalid = 1'b0;
    if (mw && mwl) begin m_bvalid = 1'b1; m_bresp = cfg_bresp; end
    drive_master();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_models();
    repeat (2) cycle();
    resetn = 1'b1;
    cycle();
    clear_logs();
  endtask

  task automatic run_until_acks(input string tag, input int n, input int lim);
    int c;
    c = 0;
    while (ack_q.size() < n && c < lim) begin cycle(); c++; end
    chk(tag, ack_q.size(), n);
  endtask

  task automatic chk_beats(input string tag, input int base, input int p, input int nb);
    for (int k = 0; k < nb; k++)
      chk(tag, (base+k < w_q.size()) ? w_q[base+k] : 33'h1_FFFF_FFFF, {k == nb-1, bdat(p, k)});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    cfg_aw_stall = 0; cfg_w_toggle = 0; cfg_bresp = 2'b00;
    clear_models(); clear_logs();

    // Reset state
    #1 chk("rst_outs_low", outs(), '0);
    do_reset();
    chk("idle_outs", outs(), '0);

    // Single write, port 2
    start_txn(2, 32'h0000_1000, 4);
    run_until_acks("single_done", 1, 100);
    repeat (3) cycle();
    chk("single_ack_cnt", ack_q.size(), 1);
    chk("single_ack", ack_q[0], 4'b0100);
    chk("single_awaddr", aw_q.size() > 0 ? aw_q[0] : '1, 32'h0000_1000);
    chk("single_nbeats", w_q.size(), 4);
    chk_beats("single_beat", 0, 2, 4);
    chk("single_bvalid", bv_q.size() > 0 ? bv_q[0] : '1, 4'b0100);
    chk("single_bresp", bresp_q.size() > 0 ? bresp_q[0] : '1, 8'h00);
    chk("single_viol", viol, 0);

    // Downstream stalls: AW held off 3 cycles, W ready toggling
    cfg_aw_stall = 3; cfg_w_toggle = 1;
    do_reset();
    start_txn(0, 32'h2000_0040, 5);
    run_until_acks("stall_done", 1, 200);
    chk("stall_ack", ack_q[0], 4'b0001);
    chk("stall_awaddr", aw_q.size() > 0 ? aw_q[0] : '1, 32'h2000_0040);
    chk("stall_aw_wait", (aw_fire_q.size() > 0 && awv_rise_q.size() > 0) ? aw_fire_q[0] - awv_rise_q[0] : -1, 3);
    chk("stall_nbeats", w_q.size(), 5);
    chk_beats("stall_beat", 0, 0, 5);
    chk("stall_viol", viol, 0);
    cfg_aw_stall = 0; cfg_w_toggle = 0;

    // Contention: all ports at once, round-robin from port 0 after reset
    do_reset();
    for (int p = 0; p < P; p++) start_txn(p, 32'h0000_3000 + 32'(p*16), p+1);
    run_until_acks("rr_done", 4, 400);
    for (int i = 0; i < P; i++) begin
      chk("rr_ack_order", i < ack_q.size() ? ack_q[i] : '0, 4'b1 << i);
      chk("rr_awaddr", i < aw_q.size() ? aw_q[i] : '1, 32'h0000_3000 + 32'(i*16));
    end
    for (int i = 0; i < P-1; i++)
      chk("rr_gap", (i+1 < awv_rise_q.size()) ? awv_rise_q[i+1] - ack_cyc_q[i] : -1, 2);
    chk("rr_nbeats", w_q.size(), 10);
    chk_beats("rr_beat_p0", 0, 0, 1);
    chk_beats("rr_beat_p1", 1, 1, 2);
    chk_beats("rr_beat_p2", 3, 2, 3);
    chk_beats("rr_beat_p3", 6, 3, 4);
    chk("rr_viol", viol, 0);

    // Error response routed to port 1 slice only
    cfg_bresp = 2'b10;
    do_reset();
    start_txn(1, 32'h4444_0000, 2);
    run_until_acks("err_done", 1, 100);
    chk("err_ack", ack_q[0], 4'b0010);
    chk("err_bresp", bresp_q.size() > 0 ? bresp_q[0] : '1, 8'h08);
    chk("err_bvalid", bv_q.size() > 0 ? bv_q[0] : '1, 4'b0010);
    chk("err_viol", viol, 0);
    cfg_bresp = 2'b00;

    // Reset in DATA after 2 of 4 beats
    do_reset();
    start_txn(3, 32'h0000_5000, 4);
    begin
      int c;
      c = 0;
      while (w_q.size() < 2 && c < 100) begin cycle(); c++; end
    end
    chk("mid_rst_beats", w_q.size(), 2);
    resetn = 1'b0;
    #1 chk("mid_rst_outs", outs(), '0);
    clear_models();
    repeat (2) cycle();
    resetn = 1'b1;
    repeat (2) cycle();
    chk("mid_rst_no_ack", ack_q.size(), 0);
    chk("mid_rst_idle", outs(), '0);
    start_txn(0, 32'h0000_5100, 1);
    run_until_acks("mid_rst_next", 1, 100);
    chk("mid_rst_next_ack", ack_q[0], 4'b0001);
    chk("mid_rst_next_aw", aw_q.size() > 0 ? aw_q[aw_q.size()-1] : '1, 32'h0000_5100);
    chk("mid_rst_wcnt", w_q.size(), 3);

    // Grant moves to port 0 during port 3's data phase
    arb_force = 1'b1; f_gv = 1'b0; f_enc = 2'd3; f_exp = 2'd3;
    do_reset();
    start_txn(3, 32'h0000_6000, 4);
    start_txn(0, 32'h0000_7000, 1);
    f_gv = 1'b1;
    begin
      int c;
      c = 0;
      while (w_q.size() < 1 && c < 100) begin cycle(); c++; end
    end
    f_enc = 2'd0;
    run_until_acks("gchg_done", 1, 100);
    f_gv = 1'b0;
    repeat (3) cycle();
    chk("gchg_ack_cnt", ack_q.size(), 1);
    chk("gchg_ack", ack_q[0], 4'b1000);
    chk("gchg_aw_cnt", aw_q.size(), 1);
    chk("gchg_awaddr", aw_q.size() > 0 ? aw_q[0] : '1, 32'h0000_6000);
    chk_beats("gchg_beat", 0, 3, 4);
    chk("gchg_viol", viol, 0);
    arb_force = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
